pipe_muxn: RTL and testbench
============================

Name: pipe_muxn

Overview:
- Parametrised N-input select mux with registered output and a 2-entry skid buffer, using a valid/ready handshake on both sides.
- Successor to the fixed 3-input combinational select.
- Used between pipeline stages (result/forwarding select into a stage register) where the downstream stage can stall and the upstream stage can flush.
- Order-preserving; sustains one transfer per cycle.

Parameters:
- NUM_IN, 3, number of data inputs (≥2).
- WIDTH, 32, data width in bits.
- SEL_W is a localparam, not overridable: SEL_W = max(1, $clog2(NUM_IN)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; empties the buffer.
- d  input  NUM_IN*WIDTH  flattened data inputs; input i = d[i*WIDTH +: WIDTH].
- s  input  SEL_W  select; meaningful only with in_valid.
- in_valid  input  1  upstream presents d/s.
- in_ready  output  1  block can accept this cycle.
- out_valid  output  1  y/y_sel hold a valid entry.
- out_ready  input  1  downstream takes the entry this cycle.
- y  output  WIDTH  selected data, head entry.
- y_sel  output  SEL_W  select value captured with y.
- sel_err  output  1  present only with PIPE_MUXN_SEL_ERR_EN (see Optional Feature).

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on port reset. No combinational path from any input to any output.
- Select rule:
  - sel_data = input s when s < NUM_IN.
  - sel_data = all-zero when s ≥ NUM_IN (e.g. NUM_IN=3, s=3 gives 0).
- Storage:
  - main register: data + sel; drives y/y_sel.
  - skid register: data + sel.
  - 2-bit state: EMPTY, ONE, FULL.
- Outputs are decoded from registered state only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
- Event definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- Transitions when not in reset and not flushing:
  - EMPTY: acc → ONE, main ← sel_data/s. Otherwise stay.
  - ONE, acc & !drn: → FULL, skid ← sel_data/s.
  - ONE, acc & drn: stay ONE, main ← sel_data/s. Full throughput.
  - ONE, !acc & drn: → EMPTY.
  - ONE, neither: hold.
  - FULL, drn: → ONE, main ← skid. acc cannot occur since in_ready=0.
  - FULL, !drn: hold.
- Latency: an entry accepted at edge N is visible on y with out_valid=1 after edge N (registered, 1 cycle).
- y and y_sel stay stable while out_valid=1 and out_ready=0.
- Priority is reset > flush > handshake.
- flush=1:
  - state → EMPTY next cycle.
  - Data accepted or drained in the flush cycle is discarded.
  - in_ready=1 the following cycle.
  - Data registers are not required to clear.
- reset=1:
  - state → EMPTY; main, skid, y, y_sel → 0.
  - out_valid=0 and in_ready=1 from the cycle after the reset edge.
  - Reset mid-transfer drops all entries.
- The bench must flag an error if d/s change while in_valid=1 & in_ready=0; the RTL does not handle this case.

Optional Feature:
- Macro: PIPE_MUXN_SEL_ERR_EN.
- Defined:
  - Port sel_err exists, registered and sticky.
  - Set on any accept (acc=1, flush=0) with s ≥ NUM_IN.
  - Cleared only by reset. flush does not clear it.
- Undefined:
  - Port sel_err and its logic are absent.
  - Out-of-range selects still produce zero data silently.

Test Plan:
- Reset: reset=1 for 2 cycles, in_valid=1 → out_valid=0, in_ready=1, y=0, y_sel=0, no entry captured.
- Streaming: NUM_IN=3, WIDTH=32, d0=0x11, d1=0x22, d2=0x33, out_ready=1, s=2,0,1 on consecutive cycles → y=0x33,0x11,0x22 one per cycle, each 1 cycle after accept; in_ready stays 1.
- Backpressure: out_ready=0, accept s=0 then s=1 → in_ready=0 after second accept, y=0x11 held. Then out_ready=1 → y=0x11 then 0x22 on consecutive cycles, in_ready=1 the cycle after the first drain.
- Flush: state FULL, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; nothing from before or during the flush cycle appears on y.
- Out-of-range select: s=3 accepted → y=0, y_sel=3. With PIPE_MUXN_SEL_ERR_EN, sel_err=1 stays set through a later flush and clears only on reset.
- Simultaneous accept+drain in ONE for 8 cycles with s cycling 0..2 → 8 outputs in order, no bubbles, state never reaches FULL.

Source files
------------

// File: rtl/pipe_muxn.sv
// rtl/pipe_muxn.sv - N-input select mux with registered output and 2-entry skid buffer
// Optional feature macro: PIPE_MUXN_SEL_ERR_EN (adds sticky sel_err output)
module pipe_muxn #(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 32,
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]        s,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y,
    output logic [SEL_W-1:0]        y_sel
`ifdef PIPE_MUXN_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    // Occupancy of the two-entry buffer; main always holds the head when non-empty.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q,  main_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;

    logic [WIDTH-1:0]   sel_data;
    logic               sel_hit;
    logic               acc;
    logic               drn;

    // Handshake flags come only from registered state, so no input reaches an output.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    assign y         = main_data_q;
    assign y_sel     = main_sel_q;

    // Select mux: an out-of-range select matches no input and yields zero data.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s == SEL_W'(i)) begin
                sel_data = d[i*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    // Next state and register loads; flush empties the buffer and discards this cycle's traffic.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d     = ST_ONE;
                        main_data_d = sel_data;
                        main_sel_d  = s;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        // Head leaves as the new entry arrives: full throughput, no bubble.
                        main_data_d = sel_data;
                        main_sel_d  = s;
                    end else if (acc) begin
                        state_d     = ST_FULL;
                        skid_data_d = sel_data;
                        skid_sel_d  = s;
                    end else if (drn) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drn) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

`ifdef PIPE_MUXN_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky error: any real accept with an out-of-range select sets it; only reset clears it.
    always_comb begin
        sel_err_d = sel_err_q | (acc & ~flush & ~sel_hit);
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    logic unused_sel_hit;
    assign unused_sel_hit = sel_hit;
`endif

endmodule

// File: tb/tb_pipe_muxn.sv
// tb/tb_pipe_muxn.sv - directed table-driven bench for pipe_muxn
module tb_pipe_muxn;

    localparam int NUM_IN = 3;
    localparam int WIDTH  = 32;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [NUM_IN*WIDTH-1:0] d;
    logic [SEL_W-1:0]        s;
    logic                    in_valid;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        y;
    logic [SEL_W-1:0]        y_sel;
`ifdef PIPE_MUXN_SEL_ERR_EN
    logic                    sel_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic             stalled_prev = 1'b0;
    logic [SEL_W-1:0] s_prev       = '0;
    logic [WIDTH-1:0] dv [NUM_IN];

    always #5 clk = ~clk;

    pipe_muxn #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .d         (d),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_sel     (y_sel)
`ifdef PIPE_MUXN_SEL_ERR_EN
        ,
        .sel_err   (sel_err)
`endif
    );

    typedef struct {
        logic             rst;
        logic             fl;
        logic             iv;
        logic [SEL_W-1:0] sv;
        logic             ordy;
        logic             ov;
        logic             ir;
        logic [WIDTH-1:0] yv;
        logic [SEL_W-1:0] ysv;
        logic             cy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [SEL_W-1:0] sv, input logic ordy,
                                input logic ov, input logic ir,
                                input logic [WIDTH-1:0] yv, input logic [SEL_W-1:0] ysv,
                                input logic cy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.sv = sv; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.yv = yv; v.ysv = ysv; v.cy = cy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then settle past it.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [SEL_W-1:0] sv, input logic ordy);
        if (stalled_prev && iv)
            chk("hold_s_while_stalled", 32'(sv), 32'(s_prev));
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        s         = sv;
        out_ready = ordy;
        stalled_prev = iv && !in_ready;
        s_prev       = sv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dv[0] = 32'h11;
        dv[1] = 32'h22;
        dv[2] = 32'h33;
        d = {dv[2], dv[1], dv[0]};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; s = '0; out_ready = 1'b0;

        //                rst fl iv  s   ordy  ov ir  y       ysel cy
        // reset with in_valid high captures nothing
        vecs.push_back(mk(1, 0, 1, 2'd2, 0,    0, 1, 32'h00, 2'd0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd2, 0,    0, 1, 32'h00, 2'd0, 1));
        // streaming s=2,0,1
        vecs.push_back(mk(0, 0, 1, 2'd2, 1,    1, 1, 32'h33, 2'd2, 0));
        vecs.push_back(mk(0, 0, 1, 2'd0, 1,    1, 1, 32'h11, 2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd1, 1,    1, 1, 32'h22, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    0, 1, 32'h00, 2'd0, 0));
        // backpressure then release
        vecs.push_back(mk(0, 0, 1, 2'd0, 0,    1, 1, 32'h11, 2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd1, 0,    1, 0, 32'h11, 2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 2'd1, 0,    1, 0, 32'h11, 2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    1, 1, 32'h22, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    0, 1, 32'h00, 2'd0, 0));
        // flush from FULL with in_valid high
        vecs.push_back(mk(0, 0, 1, 2'd2, 0,    1, 1, 32'h33, 2'd2, 0));
        vecs.push_back(mk(0, 0, 1, 2'd0, 0,    1, 0, 32'h33, 2'd2, 0));
        vecs.push_back(mk(0, 1, 1, 2'd0, 0,    0, 1, 32'h00, 2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    0, 1, 32'h00, 2'd0, 0));
        // flush in ONE with accept and drain in the same cycle
        vecs.push_back(mk(0, 0, 1, 2'd1, 0,    1, 1, 32'h22, 2'd1, 0));
        vecs.push_back(mk(0, 1, 1, 2'd2, 1,    0, 1, 32'h00, 2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    0, 1, 32'h00, 2'd0, 0));
        // out-of-range select gives zero data with the raw select
        vecs.push_back(mk(0, 0, 1, 2'd3, 0,    1, 1, 32'h00, 2'd3, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 1,    0, 1, 32'h00, 2'd0, 0));
        // reset while FULL drops everything and zeroes y/y_sel
        vecs.push_back(mk(0, 0, 1, 2'd2, 0,    1, 1, 32'h33, 2'd2, 0));
        vecs.push_back(mk(0, 0, 1, 2'd1, 0,    1, 0, 32'h33, 2'd2, 0));
        vecs.push_back(mk(1, 0, 1, 2'd1, 0,    0, 1, 32'h00, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 0,    0, 1, 32'h00, 2'd0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].sv, vecs[i].ordy);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            if (vecs[i].ov || vecs[i].cy) begin
                chk($sformatf("v%0d_y", i), y, vecs[i].yv);
                chk($sformatf("v%0d_y_sel", i), 32'(y_sel), 32'(vecs[i].ysv));
            end
        end

        // Eight back-to-back accept+drain cycles: one result per cycle, never FULL.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, SEL_W'(k % 3), 1'b1);
            chk($sformatf("tp%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("tp%0d_in_ready", k), 32'(in_ready), 32'd1);
            chk($sformatf("tp%0d_y", k), y, dv[k % 3]);
            chk($sformatf("tp%0d_y_sel", k), 32'(y_sel), 32'(k % 3));
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("tp_drain_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_MUXN_SEL_ERR_EN
        chk("sel_err_after_reset", 32'(sel_err), 32'd0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        chk("sel_err_in_range", 32'(sel_err), 32'd0);
        step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        chk("sel_err_set", 32'(sel_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("sel_err_flush_keeps", 32'(sel_err), 32'd1);
        chk("sel_err_flush_empty", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("sel_err_sticky", 32'(sel_err), 32'd1);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("sel_err_reset_clears", 32'(sel_err), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        chk("sel_err_flush_accept_ignored", 32'(sel_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
